usr_param: RTL and testbench
============================

USR_PARAM -- requirements
Module: usr_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width, legal values ≥2.
REQ-002 SHALL have parameter CNT_W, default 4: width of `count`; `count` values above WIDTH SHALL still execute exactly `count` steps.
REQ-003 `clk` in 1: single clock; all state SHALL update on the rising edge.
REQ-004 `rst_n` in 1: reset, asynchronous and active-low.
REQ-005 `en` in 1: single-step enable; applies `mode` on this edge when idle.
REQ-006 `mode` in 3: operation select.
REQ-007 `data_in` in WIDTH: parallel load data.
REQ-008 `serial_in` in 1: fill bit for logical shifts.
REQ-009 `start` in 1: request a multi-step operation.
REQ-010 `count` in CNT_W: number of steps for `start`.
REQ-011 `data_out` out WIDTH: register contents.
REQ-012 `shift_out` out 1: last bit ejected by a shift or rotate.
REQ-013 `busy` out 1: multi-step operation in progress.
REQ-014 `done` out 1: one-cycle completion pulse.

Function
REQ-015 `mode` encoding SHALL be as follows:
- 000 hold.
- 001 shift right logical: {serial_in, d[W-1:1]}.
- 010 shift left logical: {d[W-2:0], serial_in}.
- 011 parallel load from `data_in`.
- 100 rotate right: {d[0], d[W-1:1]}.
- 101 rotate left: {d[W-2:0], d[W-1]}.
- 110 arithmetic shift right: {d[W-1], d[W-1:1]}.
- 111 reserved, treated as hold.
REQ-016 `shift_out` update rules:
- Right-type step (001/100/110): SHALL capture pre-step d[0].
- Left-type step (010/101): SHALL capture pre-step d[W-1].
- Hold, load and reserved: SHALL leave it unchanged.
REQ-017 Idle single step:
- Condition: `busy`=0, `start`=0, `en`=1.
- Action: SHALL apply `mode` once on that edge, with zero latency to `data_out` after the edge.
- If `en`=0: SHALL hold.
REQ-018 FSM states SHALL be IDLE and RUN; `busy`=1 exactly when in RUN.
REQ-019 `start`=1 in IDLE SHALL take priority over `en`, with these actions on that edge:
- Latch `mode` and `count`.
- Perform no shift.
- Enter RUN if the latched count > 0 and the latched mode is a shift/rotate (001, 010, 100, 101, 110).
REQ-020 `start` with count=0, or with mode 000/011/111, SHALL:
- Stay in IDLE.
- Leave `data_out` and `shift_out` unchanged.
- Assert `done` for the one cycle following the accept edge.
REQ-021 RUN behaviour:
- Each edge SHALL apply the latched mode once and decrement an internal remaining counter.
- The edge performing the last step SHALL return to IDLE, clear `busy` and set `done` for exactly one cycle.
- `busy` is therefore high for exactly `count` cycles.
REQ-022 While in RUN, `start`, `en`, `mode` and `count` SHALL be ignored; `serial_in` SHALL be sampled live on every step.
REQ-023 `start` asserted on the cycle `done` is high (IDLE) SHALL be accepted normally, allowing back-to-back operations.
REQ-024 `done` SHALL never be high in the same cycle as `busy`.

Reset
REQ-025 While `rst_n`=0, independent of `clk` and including mid-RUN, the block SHALL force the following:
- `data_out`=0.
- `shift_out`=0.
- `busy`=0.
- `done`=0.
- FSM=IDLE.
- Remaining counter=0.
REQ-026 Any in-flight operation SHALL be abandoned with no `done` pulse; the first edge after `rst_n` rises SHALL behave as idle.

Verification (WIDTH=8, CNT_W=4)
REQ-027 Load then rotate: `en`=1 mode=011 data_in=A5, next edge mode=100 → `data_out`=D2, `shift_out`=1.
REQ-028 Arithmetic vs logical shift:
- Load 80, mode=110 one step → C0, `shift_out`=0.
- Reload 80, mode=001 with serial_in=0 → 40.
REQ-029 Multi-step rotate: `data_out`=81, start mode=101 count=3 → the following response:
- `busy` high 3 cycles with values 03, 06, 0C.
- `done` pulses with final value 0C.
- `shift_out`=0.
REQ-030 Zero-count start: start count=0 → `busy` stays 0, `done` pulses 1 cycle, `data_out` unchanged.
REQ-031 Inputs ignored during RUN: start mode=010 count=5 on 01 with serial_in=0, toggling start/en/mode mid-run → result 20 after 5 steps, single `done`.
REQ-032 Reset mid-run: `rst_n` low during RUN → all outputs 0 immediately; no `done` after release.

Source files
------------

// File: rtl/usr_param_if.sv
// Bundles the operation controls and register outputs of the universal shift register.
// The master modport drives the controls; the slave modport is the register itself.
interface usr_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_out;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, data_in, serial_in, start, count,
        input  data_out, shift_out, busy, done
    );

    modport slave (
        input  en, mode, data_in, serial_in, start, count,
        output data_out, shift_out, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// Universal shift register: single steps when idle, or a counted run of one
// shift/rotate mode.
module usr_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    usr_param_if.slave bus
);
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SRL  = 3'b001;
    localparam logic [2:0] M_SLL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_SRA  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   step_res;

    // Result packed as {shift_out, data}; hold/load/reserved keep shift_out.
    function automatic logic [WIDTH:0] apply_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] din,
        input logic             sin,
        input logic             so
    );
        logic [WIDTH-1:0] n;
        logic             s;
        n = d;
        s = so;
        case (m)
            M_SRL:   begin n = {sin, d[WIDTH-1:1]};      s = d[0];       end
            M_SLL:   begin n = {d[WIDTH-2:0], sin};      s = d[WIDTH-1]; end
            M_LOAD:  begin n = din;                                      end
            M_ROR:   begin n = {d[0], d[WIDTH-1:1]};     s = d[0];       end
            M_ROL:   begin n = {d[WIDTH-2:0], d[WIDTH-1]}; s = d[WIDTH-1]; end
            M_SRA:   begin n = {d[WIDTH-1], d[WIDTH-1:1]}; s = d[0];     end
            default: begin                                               end
        endcase
        return {s, n};
    endfunction

    function automatic logic is_shift(input logic [2:0] m);
        return (m == M_SRL) || (m == M_SLL) || (m == M_ROR) ||
               (m == M_ROL) || (m == M_SRA);
    endfunction

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sout_d   = sout_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        step_res = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Accept edge only latches; shifting starts on the next edge.
                    mode_d = bus.mode;
                    if ((bus.count != '0) && is_shift(bus.mode)) begin
                        rem_d   = bus.count;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    step_res = apply_step(bus.mode, data_q, bus.data_in,
                                          bus.serial_in, sout_q);
                    data_d   = step_res[WIDTH-1:0];
                    sout_d   = step_res[WIDTH];
                end
            end
            RUN: begin
                step_res = apply_step(mode_q, data_q, bus.data_in,
                                      bus.serial_in, sout_q);
                data_d   = step_res[WIDTH-1:0];
                sout_d   = step_res[WIDTH];
                rem_d    = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            sout_q  <= 1'b0;
            rem_q   <= '0;
            mode_q  <= M_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.shift_out = sout_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_usr_param.sv
// Directed bench for usr_param (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_usr_param;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    usr_param_if #(.WIDTH(8), .CNT_W(4)) bus ();

    usr_param #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] d,
                         input logic s, input logic st, input logic [3:0] c);
        bus.en        = e;
        bus.mode      = m;
        bus.data_in   = d;
        bus.serial_in = s;
        bus.start     = st;
        bus.count     = c;
    endtask

    task automatic load(input logic [7:0] d);
        drive(1'b1, 3'b011, d, 1'b0, 1'b0, 4'd0);
        tick();
    endtask

    initial begin
        int ndone;
        int nsteps;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        #12;
        check_eq("rst_data", bus.data_out, 8'h00);
        check_eq("rst_sout", bus.shift_out, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load then rotate right
        load(8'hA5);
        check_eq("load_a5", bus.data_out, 8'hA5);
        drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("ror_data", bus.data_out, 8'hD2);
        check_eq("ror_sout", bus.shift_out, 1'b1);
        drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("en0_hold", bus.data_out, 8'hD2);

        // Arithmetic vs logical right shift
        load(8'h80);
        drive(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("sra_data", bus.data_out, 8'hC0);
        check_eq("sra_sout", bus.shift_out, 1'b0);
        load(8'h80);
        drive(1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("srl_data", bus.data_out, 8'h40);
        drive(1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 4'd0);
        tick();
        check_eq("sll_data", bus.data_out, 8'h81);
        check_eq("sll_sout", bus.shift_out, 1'b0);
        drive(1'b1, 3'b111, 8'hFF, 1'b1, 1'b0, 4'd0);
        tick();
        check_eq("rsvd_hold", bus.data_out, 8'h81);

        // Multi-step rotate left x3 from 81
        drive(1'b0, 3'b101, 8'h00, 1'b0, 1'b1, 4'd3);
        tick();
        check_eq("rol3_acc_busy", bus.busy, 1'b1);
        check_eq("rol3_acc_data", bus.data_out, 8'h81);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("rol3_s1", bus.data_out, 8'h03);
        check_eq("rol3_s1_sout", bus.shift_out, 1'b1);
        check_eq("rol3_s1_busy", bus.busy, 1'b1);
        tick();
        check_eq("rol3_s2", bus.data_out, 8'h06);
        check_eq("rol3_s2_busy", bus.busy, 1'b1);
        tick();
        check_eq("rol3_s3", bus.data_out, 8'h0C);
        check_eq("rol3_s3_sout", bus.shift_out, 1'b0);
        check_eq("rol3_busy_off", bus.busy, 1'b0);
        check_eq("rol3_done", bus.done, 1'b1);
        tick();
        check_eq("rol3_done_off", bus.done, 1'b0);

        // Zero-count start and non-shift start
        drive(1'b1, 3'b001, 8'h00, 1'b1, 1'b1, 4'd0);
        tick();
        check_eq("zc_busy", bus.busy, 1'b0);
        check_eq("zc_done", bus.done, 1'b1);
        check_eq("zc_data", bus.data_out, 8'h0C);
        drive(1'b0, 3'b011, 8'hEE, 1'b0, 1'b1, 4'd5);
        tick();
        check_eq("ld_start_busy", bus.busy, 1'b0);
        check_eq("ld_start_done", bus.done, 1'b1);
        check_eq("ld_start_data", bus.data_out, 8'h0C);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        check_eq("ld_start_done_off", bus.done, 1'b0);

        // Inputs ignored during run: SLL x5 on 01
        load(8'h01);
        drive(1'b0, 3'b010, 8'h00, 1'b0, 1'b1, 4'd5);
        tick();
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 3'(i + 3), 8'hFF, 1'b0, ~i[0], 4'(i));
            tick();
            if (bus.done) ndone++;
            if (bus.busy && bus.done) check_eq("busy_and_done", 1'b1, 1'b0);
            check_eq("sll5_step", bus.data_out, 8'h01 << (i + 1));
        end
        check_eq("sll5_done_now", bus.done, 1'b1);
        // Back-to-back start on the done cycle: rotate right once
        drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b1, 4'd1);
        tick();
        check_eq("b2b_busy", bus.busy, 1'b1);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        if (bus.done) ndone++;
        check_eq("b2b_data", bus.data_out, 8'h10);
        check_eq("b2b_done", bus.done, 1'b1);
        tick();
        if (bus.done) ndone++;
        check_eq("done_pulses", ndone, 2);

        // count above WIDTH: ROL x15 on 01 -> 80
        load(8'h01);
        drive(1'b0, 3'b101, 8'h00, 1'b0, 1'b1, 4'd15);
        tick();
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        nsteps = 0;
        while (!bus.done && nsteps < 40) begin
            tick();
            nsteps++;
        end
        check_eq("rol15_steps", nsteps, 15);
        check_eq("rol15_data", bus.data_out, 8'h80);
        check_eq("rol15_sout", bus.shift_out, 1'b0);

        // Reset mid-run
        load(8'hF0);
        drive(1'b0, 3'b001, 8'h00, 1'b1, 1'b1, 4'd8);
        tick();
        drive(1'b0, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0);
        tick();
        tick();
        check_eq("mr_busy_pre", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_data", bus.data_out, 8'h00);
        check_eq("mr_sout", bus.shift_out, 1'b0);
        check_eq("mr_busy", bus.busy, 1'b0);
        check_eq("mr_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done || bus.busy) ndone++;
        end
        check_eq("mr_quiet", ndone, 0);
        check_eq("mr_data_after", bus.data_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
